// File: rtl/audio_ring_ram.sv
// Multi-channel circular audio sample store: frame capture, delay-line engine reads and CPU iomem access.
// Optional status register at word index CHANNELS*DEPTH is enabled by defining AUDIO_RING_STATUS_EN.
module audio_ring_ram #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned WIDTH     = 16,
    parameter logic [7:0]  ADDR_BASE = 8'h64,
    localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned PTR_W    = $clog2(DEPTH)
) (
    input  logic                        ck,
    input  logic                        rst,
    input  logic                        iomem_valid,
    output logic                        iomem_ready,
    input  logic [3:0]                  iomem_wstrb,
    input  logic [31:0]                 iomem_addr,
    input  logic [31:0]                 iomem_wdata,
    output logic [31:0]                 iomem_rdata,
    input  logic                        allow_cpu_writes,
    input  logic                        frame_strobe,
    input  logic [CHANNELS*WIDTH-1:0]   frame_in,
    input  logic                        rd_req,
    input  logic [CH_W-1:0]             rd_chan,
    input  logic [PTR_W-1:0]            rd_offset,
    output logic                        rd_valid,
    output logic [WIDTH-1:0]            rd_data,
    output logic [PTR_W-1:0]            wr_ptr,
    output logic                        overrun
);

    localparam int unsigned WORDS  = CHANNELS * DEPTH;
    localparam int unsigned RAM_AW = CH_W + PTR_W;
    localparam int unsigned IDX_W  = 22;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_RD_DONE,
        ST_IO_DONE
    } state_e;

    state_e                      state_q, state_d;
    logic [CH_W-1:0]             ch_q, ch_d;
    logic [CHANNELS*WIDTH-1:0]   frame_q, frame_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic                        overrun_q, overrun_d;
    logic                        rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0]            rd_data_q, rd_data_d;
    logic                        io_ready_q, io_ready_d;
    logic [31:0]                 io_rdata_q, io_rdata_d;

    logic [WIDTH-1:0]            mem [WORDS];

    logic                        ram_we_c;
    logic [RAM_AW-1:0]           ram_addr_c;
    logic [WIDTH-1:0]            ram_wdata_c;
    logic                        ovr_set_c;
    logic                        ovr_clr_c;

    logic                        io_sel_c;
    logic                        io_write_c;
    logic [IDX_W-1:0]            io_idx_c;
    logic                        io_in_range_c;
    logic [PTR_W-1:0]            rd_slot_c;
    logic                        rd_chan_ok_c;
    logic                        unused_bits_c;

    assign io_sel_c      = iomem_valid && (iomem_addr[31:24] == ADDR_BASE);
    assign io_write_c    = |iomem_wstrb;
    assign io_idx_c      = iomem_addr[23:2];
    assign io_in_range_c = io_idx_c < IDX_W'(WORDS);
    assign unused_bits_c = ^{iomem_addr[1:0], iomem_wdata};

    // Delay-line slot: offset 0 addresses the most recently completed frame.
    assign rd_slot_c = wr_ptr_q - PTR_W'(1) - rd_offset;

    // Channel ids beyond CHANNELS only exist when CHANNELS is not a power of two.
    generate
        if (CHANNELS == (1 << CH_W)) begin : g_chan_full
            assign rd_chan_ok_c = 1'b1;
        end else begin : g_chan_part
            assign rd_chan_ok_c = (rd_chan <= CH_W'(CHANNELS - 1));
        end
    endgenerate

    // Next-state, single RAM port arbitration (capture > engine read > iomem) and output data.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        frame_d     = frame_q;
        wr_ptr_d    = wr_ptr_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        io_ready_d  = 1'b0;
        io_rdata_d  = 32'd0;
        ram_we_c    = 1'b0;
        ram_addr_c  = '0;
        ram_wdata_c = '0;
        ovr_set_c   = 1'b0;
        ovr_clr_c   = 1'b0;

        case (state_q)
            ST_CAPTURE: begin
                ram_we_c    = 1'b1;
                ram_addr_c  = {ch_q, wr_ptr_q};
                ram_wdata_c = frame_q[32'(ch_q) * WIDTH +: WIDTH];
                ovr_set_c   = frame_strobe;
                if (ch_q == CH_W'(CHANNELS - 1)) begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    state_d  = ST_IDLE;
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
            end
            default: begin
                if (frame_strobe) begin
                    frame_d = frame_in;
                    ch_d    = '0;
                    state_d = ST_CAPTURE;
                end else if (state_q != ST_IDLE) begin
                    // Completion cycle: the requester still holds its request, so grant nothing.
                    state_d = ST_IDLE;
                end else if (rd_req) begin
                    ram_addr_c = {rd_chan, rd_slot_c};
                    rd_valid_d = 1'b1;
                    rd_data_d  = rd_chan_ok_c ? mem[ram_addr_c] : '0;
                    state_d    = ST_RD_DONE;
                end else if (io_sel_c) begin
                    io_ready_d = 1'b1;
                    state_d    = ST_IO_DONE;
                    if (io_in_range_c) begin
                        ram_addr_c  = RAM_AW'(io_idx_c);
                        ram_wdata_c = iomem_wdata[WIDTH-1:0];
                        if (io_write_c) begin
                            ram_we_c = allow_cpu_writes;
                        end else begin
                            io_rdata_d = 32'($signed(mem[ram_addr_c]));
                        end
                    end
`ifdef AUDIO_RING_STATUS_EN
                    else if (io_idx_c == IDX_W'(WORDS)) begin
                        if (io_write_c) begin
                            ovr_clr_c = iomem_wdata[31];
                        end else begin
                            io_rdata_d     = 32'(wr_ptr_q);
                            io_rdata_d[31] = overrun_q;
                        end
                    end
`endif
                end
            end
        endcase

        // A set in the same cycle as a clear wins.
        overrun_d = (overrun_q & ~ovr_clr_c) | ovr_set_c;
    end

    always_ff @(posedge ck) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            frame_q    <= '0;
            wr_ptr_q   <= '0;
            overrun_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            io_ready_q <= 1'b0;
            io_rdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            frame_q    <= frame_d;
            wr_ptr_q   <= wr_ptr_d;
            overrun_q  <= overrun_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            io_ready_q <= io_ready_d;
            io_rdata_q <= io_rdata_d;
        end
    end

    // Sample storage keeps its contents across reset; writes are blocked while reset is held.
    always_ff @(posedge ck) begin
        if (rst && ram_we_c) begin
            mem[ram_addr_c] <= ram_wdata_c;
        end
    end

    assign iomem_ready = io_ready_q;
    assign iomem_rdata = io_rdata_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign wr_ptr      = wr_ptr_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_audio_ring_ram.sv
// Directed bench for audio_ring_ram: ring model plus queues of expected engine/iomem read data.
module tb_audio_ring_ram;

    localparam int CH = 4;
    localparam int DP = 32;
    localparam int W  = 16;

    logic            ck = 1'b0;
    logic            rst;
    logic            iomem_valid;
    logic            iomem_ready;
    logic [3:0]      iomem_wstrb;
    logic [31:0]     iomem_addr;
    logic [31:0]     iomem_wdata;
    logic [31:0]     iomem_rdata;
    logic            allow_cpu_writes;
    logic            frame_strobe;
    logic [CH*W-1:0] frame_in;
    logic            rd_req;
    logic [1:0]      rd_chan;
    logic [4:0]      rd_offset;
    logic            rd_valid;
    logic [W-1:0]    rd_data;
    logic [4:0]      wr_ptr;
    logic            overrun;

    audio_ring_ram dut (
        .ck               (ck),
        .rst              (rst),
        .iomem_valid      (iomem_valid),
        .iomem_ready      (iomem_ready),
        .iomem_wstrb      (iomem_wstrb),
        .iomem_addr       (iomem_addr),
        .iomem_wdata      (iomem_wdata),
        .iomem_rdata      (iomem_rdata),
        .allow_cpu_writes (allow_cpu_writes),
        .frame_strobe     (frame_strobe),
        .frame_in         (frame_in),
        .rd_req           (rd_req),
        .rd_chan          (rd_chan),
        .rd_offset        (rd_offset),
        .rd_valid         (rd_valid),
        .rd_data          (rd_data),
        .wr_ptr           (wr_ptr),
        .overrun          (overrun)
    );

    always #5 ck = ~ck;

    typedef struct {
        logic [31:0] v;
        bit          care;
    } io_exp_t;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] model [CH][DP];
    int          wptr = 0;
    io_exp_t     io_q[$];
    logic [15:0] rd_q[$];
    io_exp_t     mon_io;
    logic [15:0] mon_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    function automatic logic [15:0] fv(input int k, input int c);
        return 16'(256 * k + c);
    endfunction

    function automatic logic [31:0] sx(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    task automatic set_frame(input int k);
        for (int c = 0; c < CH; c++) frame_in[c*W +: W] = fv(k, c);
    endtask

    task automatic commit(input int k);
        for (int c = 0; c < CH; c++) model[c][wptr] = fv(k, c);
        wptr = (wptr + 1) % DP;
    endtask

    task automatic strobe_frame(input int k);
        set_frame(k);
        frame_strobe = 1'b1;
        tick();
        frame_strobe = 1'b0;
        commit(k);
        repeat (CH + 1) tick();
    endtask

    // Requester holds valid through the ready cycle, as a synchronous master would.
    task automatic io_acc(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                          input logic [31:0] exp, input string tag);
        int n;
        io_q.push_back('{exp, ws == 4'h0});
        iomem_addr  = addr;
        iomem_wdata = wd;
        iomem_wstrb = ws;
        iomem_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (n < 50 && iomem_ready !== 1'b1);
        tick();
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        chk({tag, "_lat"}, 32'(n), 32'd1);
        chk({tag, "_rdata_after"}, iomem_rdata, 32'd0);
    endtask

    task automatic eng_rd(input int c, input int off, input string tag);
        int n;
        int slot;
        slot = (wptr - 1 - off + 2 * DP) % DP;
        rd_q.push_back(model[c][slot]);
        rd_chan   = 2'(c);
        rd_offset = 5'(off);
        rd_req    = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (n < 50 && rd_valid !== 1'b1);
        tick();
        rd_req = 1'b0;
        chk({tag, "_lat"}, 32'(n), 32'd1);
        chk({tag, "_single_pulse"}, 32'(rd_valid), 32'd0);
    endtask

    // Scoreboard: every completion pulse pops its expected value.
    always @(negedge ck) begin
        if (rst === 1'b1) begin
            if (rd_valid === 1'b1) begin
                if (rd_q.size() == 0) chk("rd_spurious", 32'(rd_valid), 32'd0);
                else begin
                    mon_rd = rd_q.pop_front();
                    chk("rd_data", 32'(rd_data), 32'(mon_rd));
                end
            end
            if (iomem_ready === 1'b1) begin
                if (io_q.size() == 0) chk("io_spurious", 32'(iomem_ready), 32'd0);
                else begin
                    mon_io = io_q.pop_front();
                    if (mon_io.care) chk("io_rdata", iomem_rdata, mon_io.v);
                end
            end
        end
    end

    initial begin
        int rl;
        int il;
        int cnt;

        rst = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_addr = 32'd0;
        iomem_wdata = 32'd0;
        allow_cpu_writes = 1'b0;
        frame_strobe = 1'b0;
        frame_in = '0;
        rd_req = 1'b0;
        rd_chan = 2'd0;
        rd_offset = 5'd0;
        repeat (3) tick();
        chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_ready", 32'(iomem_ready), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rdata", iomem_rdata, 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        rst = 1'b1;
        tick();

        // CPU write gating and sign-extended readback
        allow_cpu_writes = 1'b1;
        io_acc(32'h6400_0000, 32'h0000_aaaa, 4'hf, 32'd0, "wr_aaaa");
        io_acc(32'h6400_0000, 32'd0, 4'h0, 32'hffff_aaaa, "rd_aaaa");
        allow_cpu_writes = 1'b0;
        io_acc(32'h6400_0000, 32'h0000_5555, 4'hf, 32'd0, "wr_blocked");
        io_acc(32'h6400_0000, 32'd0, 4'h0, 32'hffff_aaaa, "rd_unchanged");
        allow_cpu_writes = 1'b1;

        // Channel/slot decode, out-of-range words
        io_acc(32'h6400_0080, 32'h0000_1111, 4'hf, 32'd0, "wr_c1s0");
        io_acc(32'h6400_0180, 32'h0000_4444, 4'hf, 32'd0, "wr_c3s0");
        io_acc(32'h6400_0080, 32'd0, 4'h0, 32'h0000_1111, "rd_c1s0");
        io_acc(32'h6400_0180, 32'd0, 4'h0, 32'h0000_4444, "rd_c3s0");
        io_acc(32'h6400_0200, 32'd0, 4'h0, 32'd0, "rd_idx128");
        io_acc(32'h6400_0004, 32'h0000_2222, 4'hf, 32'd0, "wr_c0s1");
        io_acc(32'h6400_0204, 32'h0000_7777, 4'hf, 32'd0, "wr_idx129");
        io_acc(32'h6400_0004, 32'd0, 4'h0, 32'h0000_2222, "rd_c0s1_noalias");

        // Unselected address gets no ready
        iomem_addr = 32'h6500_0000;
        iomem_valid = 1'b1;
        cnt = 0;
        repeat (5) begin
            tick();
            if (iomem_ready) cnt++;
        end
        iomem_valid = 1'b0;
        chk("unsel_no_ready", 32'(cnt), 32'd0);
        tick();

        // Three captured frames and delay-line reads
        for (int k = 1; k <= 3; k++) strobe_frame(k);
        chk("wr_ptr_3", 32'(wr_ptr), 32'd3);
        eng_rd(2, 0, "rd_c2_off0");
        eng_rd(2, 2, "rd_c2_off2");
        io_acc(32'h6400_0080, 32'd0, 4'h0, sx(fv(1, 1)), "rd_c1s0_captured");

        // Wrap after 33 frames
        for (int k = 4; k <= 33; k++) strobe_frame(k);
        chk("wr_ptr_wrap", 32'(wr_ptr), 32'd1);
        for (int c = 0; c < CH; c++) begin
            eng_rd(c, 0, "rd_wrap_off0");
            eng_rd(c, 31, "rd_wrap_off31");
        end

        // Strobe during capture: overrun, second frame dropped
        chk("overrun_pre", 32'(overrun), 32'd0);
        set_frame(40);
        frame_strobe = 1'b1;
        tick();
        frame_strobe = 1'b0;
        commit(40);
        tick();
        set_frame(41);
        frame_strobe = 1'b1;
        tick();
        frame_strobe = 1'b0;
        repeat (CH + 1) tick();
        chk("overrun_set", 32'(overrun), 32'd1);
        chk("overrun_wr_ptr", 32'(wr_ptr), 32'(wptr));
        eng_rd(0, 0, "rd_after_overrun");
`ifdef AUDIO_RING_STATUS_EN
        io_acc(32'h6400_0200, 32'd0, 4'h0, 32'h8000_0000 | 32'(wptr), "status_rd");
        allow_cpu_writes = 1'b0;
        io_acc(32'h6400_0200, 32'h8000_0000, 4'hf, 32'd0, "status_clr");
        allow_cpu_writes = 1'b1;
        chk("overrun_cleared", 32'(overrun), 32'd0);
`else
        io_acc(32'h6400_0200, 32'h8000_0000, 4'hf, 32'd0, "idx128_wr");
        io_acc(32'h6400_0200, 32'd0, 4'h0, 32'd0, "idx128_rd");
        chk("overrun_sticky", 32'(overrun), 32'd1);
`endif

        // Strobe, engine read and iomem read in the same cycle
        set_frame(50);
        commit(50);
        rd_q.push_back(model[1][(wptr - 1 + DP) % DP]);
        io_q.push_back('{sx(model[2][5]), 1'b1});
        frame_strobe = 1'b1;
        rd_req = 1'b1;
        rd_chan = 2'd1;
        rd_offset = 5'd0;
        iomem_addr = 32'h6400_0000 + 32'((2 * DP + 5) * 4);
        iomem_wstrb = 4'h0;
        iomem_valid = 1'b1;
        rl = 0;
        il = 0;
        for (int n = 1; n <= 14; n++) begin
            tick();
            if (n == 1) frame_strobe = 1'b0;
            if (rl != 0) rd_req = 1'b0;
            if (il != 0) iomem_valid = 1'b0;
            if (rd_valid && rl == 0) rl = n;
            if (iomem_ready && il == 0) il = n;
        end
        rd_req = 1'b0;
        iomem_valid = 1'b0;
        chk("simul_rd_lat", 32'(rl), 32'(CH + 2));
        chk("simul_io_lat", 32'(il), 32'(CH + 4));
        chk("simul_wr_ptr", 32'(wr_ptr), 32'(wptr));

        // Reset in the middle of a capture
        set_frame(60);
        frame_strobe = 1'b1;
        tick();
        frame_strobe = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        wptr = 0;
        chk("midrst_wr_ptr", 32'(wr_ptr), 32'd0);
        chk("midrst_overrun", 32'(overrun), 32'd0);
        cnt = 0;
        repeat (6) begin
            tick();
            if (iomem_ready || rd_valid) cnt++;
        end
        chk("midrst_quiet", 32'(cnt), 32'd0);
        chk("midrst_wr_ptr_hold", 32'(wr_ptr), 32'd0);
        strobe_frame(61);
        chk("post_rst_wr_ptr", 32'(wr_ptr), 32'd1);
        eng_rd(3, 0, "rd_post_rst");

        repeat (2) tick();
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
        chk("io_q_drained", 32'(io_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/audio_ring_ram.md
Name: audio_ring_ram

Overview:
- Parametrised multi-channel circular sample store for the audio engine.
- Replaces the fixed 32-sample-per-channel audio RAM window at 0x64000000.
- Adds a live capture path: one frame (all channels) is written per sample strobe at a rotating write pointer.
- Has a delay-line read port for the DSP sequencer (offset relative to newest sample) and keeps iomem CPU access for preload/inspection.

Parameters:
- CHANNELS, 4, number of audio channels (≥1).
- DEPTH, 32, samples per channel; power of 2, ≥4.
- WIDTH, 16, sample width in bits (≤32).
- ADDR_BASE, 8'h64, iomem_addr[31:24] decode value.

Ports:
- ck  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- iomem_valid  in  1  CPU bus request.
- iomem_ready  out  1  one-cycle CPU completion pulse.
- iomem_wstrb  in  4  nonzero = write.
- iomem_addr  in  32  byte address.
- iomem_wdata  in  32  write data; low WIDTH bits used.
- iomem_rdata  out  32  read data, sign-extended sample.
- allow_cpu_writes  in  1  control-register gate for CPU writes.
- frame_strobe  in  1  one-cycle pulse: capture frame_in.
- frame_in  in  CHANNELS*WIDTH  channel c at bits [c*WIDTH +: WIDTH].
- rd_req  in  1  engine read request, held until rd_valid.
- rd_chan  in  $clog2(CHANNELS)  engine read channel.
- rd_offset  in  $clog2(DEPTH)  0 = newest sample.
- rd_valid  out  1  one-cycle pulse, rd_data valid.
- rd_data  out  WIDTH  engine read data.
- wr_ptr  out  $clog2(DEPTH)  next slot to be written.
- overrun  out  1  sticky: strobe lost.

Behaviour:
- Storage: single-port RAM of CHANNELS*DEPTH words; word address = chan*DEPTH + slot. One access per cycle.
- Reset (rst low at a clock edge):
  - wr_ptr=0, overrun=0, iomem_ready=0, rd_valid=0, iomem_rdata=0, rd_data=0, FSM=IDLE.
  - RAM contents are not cleared.
  - Requests present while rst is low are ignored.
  - Reset mid-capture aborts the capture; wr_ptr is not advanced.
- FSM states:
  - IDLE: frame_strobe → CAPTURE with ch=0; frame_in is latched on the strobe cycle.
  - CAPTURE: writes channel ch to slot wr_ptr, one channel per cycle. After the last channel, wr_ptr <= wr_ptr+1 mod DEPTH and → IDLE. Capture takes CHANNELS cycles.
  - A frame_strobe during CAPTURE sets overrun; that frame is dropped.
- Arbitration priority when the RAM is free: capture > engine read > iomem. A losing request waits; no request is lost.
- Engine read:
  - Granted in IDLE only.
  - Slot = (wr_ptr - 1 - rd_offset) mod DEPTH.
  - rd_valid and rd_data appear exactly 1 cycle after grant. Minimum latency is 1 cycle; there is no new grant on the rd_valid cycle.
  - rd_req must be held until rd_valid.
- iomem access:
  - Selected when iomem_addr[31:24]==ADDR_BASE; otherwise ignored, with no ready.
  - Word index = iomem_addr[23:2]. Channel = idx/DEPTH, slot = idx%DEPTH (absolute, not pointer-relative).
  - iomem_ready pulses 1 cycle after grant; iomem_rdata is valid in the same cycle and returns 0 after.
  - A write stores wdata[WIDTH-1:0] only if allow_cpu_writes=1; otherwise it is dropped but still acked.
  - idx ≥ CHANNELS*DEPTH: acked, rdata=0, write dropped.
  - Master drops valid on ready; no back-to-back ack of the same request.
- Simultaneous events: frame_strobe, rd_req and iomem in the same cycle → capture runs first, then read, then iomem.

Optional Feature:
- Macro: AUDIO_RING_STATUS_EN.
- With the macro defined:
  - Word index CHANNELS*DEPTH is a status register: read = {overrun, 31-$clog2(DEPTH) zeros, wr_ptr}.
  - A write with wdata[31]=1 clears overrun; this ignores allow_cpu_writes.
  - A clear and an overrun set in the same cycle → overrun stays 1.
- Without the macro: that index behaves as out-of-range (rdata 0), and overrun clears only on reset.

Test Plan:
- CPU write 0x0000aaaa to 0x64000000 with allow_cpu_writes=1, then read back → rdata 0xffffaaaa, iomem_ready 1 cycle after grant; repeat with allow_cpu_writes=0 → readback unchanged.
- Write 0x1111 to 0x64000080 (chan1 slot0) and 0x4444 to 0x64000180 (chan3 slot0) → reads return 0x00001111 and 0x00004444; read 0x64000200 → 0.
- Three frame_strobes: frame_in channel c = 0x100*k + c for frames k=1,2,3 → wr_ptr=3; rd_chan=2, rd_offset=0 → 0x0302; offset 2 → 0x0102; each with rd_valid 1 cycle after grant.
- 33 strobes with default parameters → wr_ptr wraps to 1; offset 0 returns the frame-33 data; offset 31 returns the frame-2 data.
- Strobe again 2 cycles after a strobe → overrun=1, wr_ptr advanced once; with AUDIO_RING_STATUS_EN, read status → bit31=1, then write 0x80000000 → overrun=0.
- Strobe, rd_req and iomem read asserted in the same cycle → 4 capture cycles, then rd_valid, then iomem_ready; assert rst low mid-capture → wr_ptr=0, overrun=0, no ready or valid.
